// File: rtl/serial_loader.sv
// Parallel-to-serial feeder: captures a word on start and emits it MSB-first
// on ld, one bit per enabled clock, with a start/busy/done handshake.
module serial_loader #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    output logic             ld,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shadow_d = data;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    shadow_d = {shadow_q[WIDTH-2:0], 1'b0};
                    if (cnt_q == LAST) begin
                        cnt_d   = FULL;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so ld has no input-to-output path.
    always_comb begin
        ld      = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        bit_cnt = cnt_q;
        unique case (state_q)
            IDLE: begin
                ld = 1'b0;
            end
            SHIFT: begin
                busy = 1'b1;
                ld   = shadow_q[WIDTH-1];
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                ld = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader with a 6-stage downstream register model
// (a = sr[5] ... f = sr[0]) fed from ld.
module tb_serial_loader;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic [5:0] data;
    logic       en;
    logic       ld;
    logic       busy;
    logic       done;
    logic [4:0] bit_cnt;

    int n_vec = 0;
    int n_err = 0;
    int busy_total = 0;
    logic [5:0] sr;

    serial_loader #(.WIDTH(6), .CNT_W(5)) dut (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .data    (data),
        .en      (en),
        .ld      (ld),
        .busy    (busy),
        .done    (done),
        .bit_cnt (bit_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge clr) begin
        if (clr) sr <= '0;
        else if (en) sr <= {sr[4:0], ld};
    end

    always @(negedge clk) begin
        if (busy === 1'b1) busy_total <= busy_total + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic e_ld,
                           input logic e_busy, input logic e_done,
                           input int e_cnt);
        chk({tag, ".ld"}, {31'd0, ld}, {31'd0, e_ld});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, e_done});
        chk({tag, ".cnt"}, {27'd0, bit_cnt}, e_cnt);
    endtask

    // One frame: optional stall of stall_n cycles before bit stall_at,
    // optional intruding start (data 010010) at bit intrude_at.
    task automatic frame(input string tag, input logic [5:0] d,
                         input int stall_at, input int stall_n,
                         input int intrude_at);
        int b0;
        data  = d;
        start = 1'b1;
        en    = 1'b1;
        tick();
        start = 1'b0;
        b0    = busy_total;
        for (int k = 0; k < 6; k++) begin
            if (k == stall_at) begin
                en = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    chk_out({tag, ".stall"}, d[5-k], 1'b1, 1'b0, k);
                    tick();
                end
                en = 1'b1;
            end
            if (k == intrude_at) begin
                start = 1'b1;
                data  = 6'b010010;
            end else begin
                start = 1'b0;
            end
            chk_out({tag, ".shift"}, d[5-k], 1'b1, 1'b0, k);
            tick();
        end
        start = 1'b0;
        chk_out({tag, ".done"}, 1'b0, 1'b0, 1'b1, 6);
        chk({tag, ".sr"}, {26'd0, sr}, {26'd0, d});
        chk({tag, ".busy_cycles"}, busy_total - b0, 6 + stall_n);
        tick();
        chk_out({tag, ".idle1"}, 1'b0, 1'b0, 1'b0, 0);
        tick();
        chk_out({tag, ".idle2"}, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        clr   = 1'b1;
        start = 1'b1;
        data  = 6'b111111;
        en    = 1'b1;
        tick();
        chk_out("rst1", 1'b0, 1'b0, 1'b0, 0);
        tick();
        chk_out("rst2", 1'b0, 1'b0, 1'b0, 0);
        clr   = 1'b0;
        start = 1'b0;
        tick();
        chk_out("post_rst1", 1'b0, 1'b0, 1'b0, 0);
        tick();
        chk_out("post_rst2", 1'b0, 1'b0, 1'b0, 0);

        frame("basic", 6'b101101, -1, 0, -1);
        frame("stall", 6'b101101, 2, 3, -1);
        frame("intrude", 6'b101101, -1, 0, 3);

        // Reset mid-frame after three bits.
        data  = 6'b101101;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk_out("mid.pre", 1'b1, 1'b1, 1'b0, 3);
        #2 clr = 1'b1;
        #1;
        chk_out("mid.async", 1'b0, 1'b0, 1'b0, 0);
        tick();
        chk_out("mid.held", 1'b0, 1'b0, 1'b0, 0);
        clr = 1'b0;
        tick();
        chk_out("mid.idle", 1'b0, 1'b0, 1'b0, 0);
        frame("after_clr", 6'b000001, -1, 0, -1);

        // Back-to-back: start held high, period of 8 cycles.
        data  = 6'b110000;
        start = 1'b1;
        en    = 1'b1;
        tick();
        for (int c = 0; c < 24; c++) begin
            int p;
            p = c % 8;
            if (p < 6) begin
                chk_out("b2b.shift", data[5-p], 1'b1, 1'b0, p);
            end else if (p == 6) begin
                chk_out("b2b.done", 1'b0, 1'b0, 1'b1, 6);
                chk("b2b.sr", {26'd0, sr}, 32'h30);
            end else begin
                chk_out("b2b.idle", 1'b0, 1'b0, 1'b0, 0);
            end
            tick();
        end
        start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
